// File: rtl/sp_adder_result_buffer_if.sv
// sp_adder_result_buffer_if: producer/consumer handshake bundle for the adder result buffer.
interface sp_adder_result_buffer_if #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_result;
   logic [3:0]    in_flags;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_result;
   logic [3:0]    out_flags;
   logic [3:0]    sticky_flags;
   logic          sticky_clear;
   logic [LW-1:0] level;
   modport master (
      output in_valid, in_result, in_flags, out_ready, sticky_clear,
      input  in_ready, out_valid, out_result, out_flags, sticky_flags, level
   );
   modport slave (
      input  in_valid, in_result, in_flags, out_ready, sticky_clear,
      output in_ready, out_valid, out_result, out_flags, sticky_flags, level
   );
endinterface

// File: rtl/sp_adder_result_buffer.sv
// sp_adder_result_buffer: first-word fall-through circular buffer of adder results with sticky IEEE flags.
module sp_adder_result_buffer #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input logic                    clk,
   input logic                    rst,
   sp_adder_result_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   logic [35:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [3:0]    r_sticky;
   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_wr;
   logic          w_rd;
   logic [35:0]   w_head;
   assign w_in_ready  = r_level < LW'(DEPTH);
   assign w_out_valid = r_level != '0;
   assign w_wr        = bus.in_valid && w_in_ready;
   assign w_rd        = w_out_valid && bus.out_ready;
   assign w_head      = r_mem[r_rptr];
   // Storage is left unreset; only occupied slots are ever observable.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= {bus.in_result, bus.in_flags};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_level  <= '0;
         r_sticky <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + PW'(1);
         if (w_rd) r_rptr <= r_rptr + PW'(1);
         if (w_wr != w_rd) r_level <= w_wr ? r_level + LW'(1) : r_level - LW'(1);
         r_sticky <= (bus.sticky_clear ? 4'b0 : r_sticky) | (w_wr ? bus.in_flags : 4'b0);
      end
   end
   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = w_out_valid;
   assign bus.out_result   = w_out_valid ? w_head[35:4] : '0;
   assign bus.out_flags    = w_out_valid ? w_head[3:0] : '0;
   assign bus.sticky_flags = r_sticky;
   assign bus.level        = r_level;
endmodule

// File: tb/tb_sp_adder_result_buffer.sv
// tb_sp_adder_result_buffer: queue-model scoreboard with directed and random traffic for the result buffer.
module tb_sp_adder_result_buffer;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   logic clk = 1'b0;
   logic rst;
   logic mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [35:0] q[$];
   logic [3:0]  m_sticky;
   logic        m_acc;
   logic        m_rd;
   always #5 clk = ~clk;
   sp_adder_result_buffer_if #(.DEPTH(DEPTH)) bus ();
   sp_adder_result_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference model: an unbounded queue limited to DEPTH by the acceptance rule.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_sticky = 4'b0;
      end else begin
         m_acc = bus.in_valid && (q.size() < DEPTH);
         m_rd  = bus.out_ready && (q.size() != 0);
         m_sticky = (bus.sticky_clear ? 4'b0 : m_sticky) | (m_acc ? bus.in_flags : 4'b0);
         if (m_rd) void'(q.pop_front());
         if (m_acc) q.push_back({bus.in_result, bus.in_flags});
      end
   end
   always @(negedge clk) begin
      if (mon_en) begin
         chk("level", 36'(bus.level), 36'(q.size()));
         chk("in_ready", 36'(bus.in_ready), 36'(q.size() < DEPTH));
         chk("out_valid", 36'(bus.out_valid), 36'(q.size() != 0));
         chk("head", {bus.out_result, bus.out_flags}, q.size() != 0 ? q[0] : 36'h0);
         chk("sticky", 36'(bus.sticky_flags), 36'(m_sticky));
      end
   end
   task automatic cyc(input logic v, input logic [31:0] r, input logic [3:0] f, input logic ordy, input logic clr);
      bus.in_valid = v;
      bus.in_result = r;
      bus.in_flags = f;
      bus.out_ready = ordy;
      bus.sticky_clear = clr;
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
   endtask
   initial begin
      int sent;
      int budget;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_result = '0;
      bus.in_flags = '0;
      bus.out_ready = 1'b0;
      bus.sticky_clear = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      chk("rst_in_ready", 36'(bus.in_ready), 36'(1));
      chk("rst_out_valid", 36'(bus.out_valid), 36'(0));
      chk("rst_out", {bus.out_result, bus.out_flags}, 36'h0);
      cyc(1'b1, 32'h3F800000, 4'b0000, 1'b0, 1'b0);
      chk("first_valid", 36'(bus.out_valid), 36'(1));
      chk("first_result", 36'(bus.out_result), 36'h3F800000);
      chk("first_level", 36'(bus.level), 36'(1));
      drain(2);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 32'h40000000 + 32'(i), 4'(i), 1'b0, 1'b0);
         if (i == 3) chk("full_in_ready", 36'(bus.in_ready), 36'(0));
      end
      chk("full_level", 36'(bus.level), 36'(4));
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", {bus.out_result, bus.out_flags}, {32'h40000000 + 32'(i), 4'(i)});
         cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      end
      chk("drained_level", 36'(bus.level), 36'(0));
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h41000000 + 32'(i), 4'h0, 1'b0, 1'b0);
      chk("full_rw_ready", 36'(bus.in_ready), 36'(0));
      cyc(1'b1, 32'h4100AAAA, 4'h2, 1'b1, 1'b0);
      chk("full_rw_level", 36'(bus.level), 36'(3));
      cyc(1'b1, 32'h4100AAAA, 4'h2, 1'b0, 1'b0);
      chk("refill_level", 36'(bus.level), 36'(4));
      drain(5);
      cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
      cyc(1'b1, 32'h42000001, 4'b0001, 1'b1, 1'b0);
      cyc(1'b1, 32'h42000002, 4'b0100, 1'b1, 1'b0);
      chk("sticky_or", 36'(bus.sticky_flags), 36'(4'b0101));
      cyc(1'b1, 32'h42000003, 4'b1000, 1'b1, 1'b1);
      chk("sticky_clr_wr", 36'(bus.sticky_flags), 36'(4'b1000));
      drain(3);
      sent = 0;
      budget = 0;
      while (sent < 10 && budget < 100) begin
         bus.in_valid = 1'b1;
         bus.in_result = 32'h43000000 + 32'(sent);
         bus.in_flags = 4'(sent);
         bus.out_ready = budget[0];
         bus.sticky_clear = 1'b0;
         if (bus.in_ready) sent++;
         @(posedge clk);
         #1;
         budget++;
      end
      chk("stream_sent", 36'(sent), 36'(10));
      drain(6);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h44000000 + 32'(i), 4'hF, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 32'h44000009, 4'hF, 1'b1, 1'b1);
      rst = 1'b0;
      chk("rst_level", 36'(bus.level), 36'(0));
      chk("rst_valid", 36'(bus.out_valid), 36'(0));
      chk("rst_sticky", 36'(bus.sticky_flags), 36'(0));
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cyc(1'($urandom_range(0, 2) != 0), $urandom, 4'($urandom), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 15) == 0));
      end
      rst = 1'b0;
      drain(6);
      chk("final_level", 36'(bus.level), 36'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
